// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to a
// synchronous-read instruction memory and buffers returned words for decode.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] pc_if,
  output logic [31:0]     instr_if,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0] r_fpc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [XLEN-1:0] r_buf_pc    [DEPTH];
  logic [31:0]     r_buf_instr [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic [OW-1:0] w_occ;
  logic          w_unused;

  // Credit check counts the slot freed by this cycle's pop, so the
  // id_ready -> imem_req path is combinational by design.
  always_comb begin
    w_pop    = if_valid && id_ready;
    w_push   = r_inflight;
    w_occ    = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
    imem_req = !reset && !redirect_valid && (w_occ < OW'(DEPTH));
  end

  assign imem_addr = r_fpc;
  assign if_valid  = (r_count != '0);
  assign pc_if     = r_buf_pc[r_head];
  assign instr_if  = r_buf_instr[r_head];
  assign w_unused  = &{1'b0, redirect_pc[1:0]};

  // Fetch PC, in-flight tracking and circular buffer; redirect beats issue/push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc         <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_fpc      <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_fpc         <= r_fpc + XLEN'(4);
        r_inflight_pc <= r_fpc;
      end
      if (w_push) begin
        r_buf_pc[r_tail]    <= r_inflight_pc;
        r_buf_instr[r_tail] <= imem_rdata;
        r_tail              <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`ifdef FETCH_PERF_EN
  // Accepted-instruction and decode-backpressure counters, free-running wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (w_pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (if_valid && !id_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues expected accepted PCs,
// a negedge monitor pops and compares them on every decode handshake.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam bit [12:0]   PAT = 13'b1110110110111;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .pc_if          (pc_if),
    .instr_if       (instr_if),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A is A ^ KEY, one-cycle read.
  always @(posedge clk) imem_rdata <= imem_addr ^ KEY;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
    @(negedge clk);
  endtask

  // Scoreboard monitor: decode ignores a pop that coincides with a redirect.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && if_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pop: got pc %h expected none", pc_if);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", pc_if, e);
        chk("pop_instr", instr_if, e ^ KEY);
      end
    end
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", pc_if, 32'h0);
    chk("rst_instr", instr_if, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Start-up stream, then a 5-cycle decode stall on pc 0x8.
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c0_req", 32'(imem_req), 32'd1); chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c1_addr", imem_addr, 32'h4); chk("c1_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c2_valid", 32'(if_valid), 32'd1); chk("c2_pc", pc_if, 32'h0);
    chk("c2_instr", instr_if, 32'hA5A5_0000); chk("c2_addr", imem_addr, 32'h8);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("c3_valid", 32'(if_valid), 32'd1); chk("c3_addr", imem_addr, 32'hC);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stall_pc", pc_if, 32'h8);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("resume_req", 32'(imem_req), 32'd1); chk("resume_addr", imem_addr, 32'h10);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with a buffered entry and a request in flight.
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    cyc(1'b0, 1'b1, 32'h100, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd_valid", 32'(if_valid), 32'd0); chk("rd_req", 32'(imem_req), 32'd1);
    chk("rd_addr", imem_addr, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd1_valid", 32'(if_valid), 32'd0); chk("rd1_addr", imem_addr, 32'h104);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rd2_valid", 32'(if_valid), 32'd1); chk("rd2_pc", pc_if, 32'h100);
    chk("rd2_instr", instr_if, 32'hA5A5_0100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // Back-to-back redirects: unaligned 0x103 then 0x200, last one wins.
    cyc(1'b0, 1'b1, 32'h103, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, 1'b0);
    chk("bb_addr", imem_addr, 32'h100); chk("bb_req", 32'(imem_req), 32'd0);
    chk("bb_valid", 32'(if_valid), 32'd0);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bb1_req", 32'(imem_req), 32'd1); chk("bb1_addr", imem_addr, 32'h200);
    chk("bb1_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bb2_valid", 32'(if_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("bb3_valid", 32'(if_valid), 32'd1); chk("bb3_pc", pc_if, 32'h200);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);

    // One-cycle reset mid-stream, then restart with interleaved stalls.
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("mrst_req", 32'(imem_req), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst_valid", 32'(if_valid), 32'd0); chk("mrst_pc", pc_if, 32'h0);
    chk("mrst_instr", instr_if, 32'h0); chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_req1", 32'(imem_req), 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_stall_rst", perf_stall, 32'd0);
`endif
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(4 * i));
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("mrst1_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 13; i++) begin
      cyc(1'b0, 1'b0, 32'h0, PAT[12-i]);
      chk("run_valid", 32'(if_valid), 32'd1);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("run_head", pc_if, 32'h28);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
`endif
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("end_valid", 32'(if_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("perf_fetched_clr", perf_fetched, 32'd0);
    chk("perf_stall_clr", perf_stall, 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
